// File: rtl/rv32i_mc_controller.sv
// rv32i_mc_controller
// Multicycle control unit for the rv32i core. It decodes the instruction
// register fields into datapath selects and write enables, covering loads,
// stores, R/I ALU ops, the six branches, JAL, JALR, LUI and AUIPC.
// Memory states wait on a ready handshake and give up into a sticky FAULT
// state after TIMEOUT idle cycles. An illegal opcode also enters FAULT.
//
// Parameters:
//   TIMEOUT  cycles a memory state may wait on mem_ready before faulting (>=1)
//   CNT_W    width of the performance counters
//
// Ports:
//   clk, rst                 clock (posedge) and asynchronous active-low reset
//   ena                      1 = run, 0 = freeze state and mask write enables
//   op, funct3, funct7       instruction register fields
//   zero, alu_lsb            ALU compare inputs used by branches
//   mem_ready                memory completes the current access
//   mem_req, mem_wr_ena      memory request / store strobe
//   adr_src                  memory address select (0 = PC, 1 = result)
//   ir_write, pc_write, reg_write   register write enables
//   alu_src_a, alu_src_b     ALU operand selects
//   res_src, imm_src         result select, immediate format
//   alu_control              ALU operation
//   fault, fault_cause       sticky fault flag and cause (01 illegal, 10 timeout)
//   instret, cycles          performance counters
//
// Optional feature: define RV32I_MC_PERF_EN to build the performance
// counters; without it, cycles and instret are tied to zero.

package rv32i_mc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_control_t;
endpackage

module rv32i_mc_controller
  import rv32i_mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             alu_lsb,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr_ena,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       res_src,
  output logic [2:0]       imm_src,
  output alu_control_t     alu_control,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_UPPER, S_JALR, S_JAL, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        next_cause;
  logic              mem_wait;
  logic              want_req, want_wr, want_ir, want_pc, want_reg;
  logic              run;

  // Only funct7[5] selects SUB/SRA; the remaining bits are intentionally ignored.
  logic unused_funct7;
  assign unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

  // Write enables and the memory request are masked while stalled or in reset.
  assign run        = ena & rst;
  assign mem_req    = want_req & run;
  assign mem_wr_ena = want_wr  & run;
  assign ir_write   = want_ir  & run;
  assign pc_write   = want_pc  & run;
  assign reg_write  = want_reg & run;

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'd0;
    case (op)
      OP_STORE:         imm_src = 3'd1;
      OP_BRANCH:        imm_src = 3'd2;
      OP_JAL:           imm_src = 3'd3;
      OP_LUI, OP_AUIPC: imm_src = 3'd4;
      default:          imm_src = 3'd0;
    endcase
  end

  // Next-state and control decode.
  always_comb begin
    next_state  = state;
    next_cause  = 2'b00;
    mem_wait    = 1'b0;
    want_req    = 1'b0;
    want_wr     = 1'b0;
    want_ir     = 1'b0;
    want_pc     = 1'b0;
    want_reg    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    res_src     = 2'b00;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_wait  = 1'b1;
        want_req  = 1'b1;
        alu_src_b = 2'b10;
        res_src   = 2'b10;
        if (mem_ready) begin
          want_ir    = 1'b1;
          want_pc    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          default: begin
            next_state = S_FAULT;
            next_cause = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_wait = 1'b1;
        want_req = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        res_src    = 2'b01;
        want_reg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_wait = 1'b1;
        want_req = 1'b1;
        want_wr  = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = (state == S_EXECI) ? 2'b01 : 2'b00;
        next_state = S_ALUWB;
        // funct7[5] picks SUB only for register-register ops, SRA for both.
        case (funct3)
          3'd0:    alu_control = (funct7[5] && state == S_EXECR) ? ALU_SUB : ALU_ADD;
          3'd1:    alu_control = ALU_SLL;
          3'd2:    alu_control = ALU_SLT;
          3'd3:    alu_control = ALU_SLTU;
          3'd4:    alu_control = ALU_XOR;
          3'd5:    alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6:    alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      S_UPPER: begin
        alu_src_a  = (op == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b  = 2'b01;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from alu_out while the ALU forms the link value.
        want_pc    = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        want_reg   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        next_state = S_FETCH;
        // Undefined funct3 codes fall through as a never-taken compare.
        case (funct3)
          3'b000:  begin alu_control = ALU_SUB;  want_pc = zero;     end
          3'b001:  begin alu_control = ALU_SUB;  want_pc = !zero;    end
          3'b100:  begin alu_control = ALU_SLT;  want_pc = alu_lsb;  end
          3'b101:  begin alu_control = ALU_SLT;  want_pc = !alu_lsb; end
          3'b110:  begin alu_control = ALU_SLTU; want_pc = alu_lsb;  end
          3'b111:  begin alu_control = ALU_SLTU; want_pc = !alu_lsb; end
          default: begin alu_control = ALU_SUB;  want_pc = 1'b0;     end
        endcase
      end
      default: begin
        next_state = S_FAULT;
      end
    endcase
    // A ready in the final allowed cycle still completes the access.
    if (mem_wait && !mem_ready && wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
      next_state = S_FAULT;
      next_cause = 2'b10;
    end
  end

  // State, wait counter and sticky fault; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
    end else if (ena) begin
      state <= next_state;
      if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                        wait_cnt <= '0;
      if (next_state == S_FAULT && state != S_FAULT) begin
        fault       <= 1'b1;
        fault_cause <= next_cause;
      end
    end
  end

`ifdef RV32I_MC_PERF_EN
  logic [CNT_W-1:0] cycles_q, instret_q;

  // Cycles count active clocks outside FAULT; an instruction retires on
  // every return to FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else if (ena) begin
      if (state != S_FAULT) cycles_q <= cycles_q + CNT_W'(1);
      if (state != S_FETCH && next_state == S_FETCH) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// tb_rv32i_mc_controller
// Self-checking bench for rv32i_mc_controller. An instruction-level model
// lists the phases each instruction class walks through and the control
// vector expected in each phase; directed and random instructions are run
// against it, followed by timeout, illegal-opcode and mid-instruction
// reset scenarios.

module tb_rv32i_mc_controller;
  import rv32i_mc_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;
`ifdef RV32I_MC_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst, ena, zero, alu_lsb, mem_ready;
  logic [6:0]       op, funct7;
  logic [2:0]       funct3;
  logic             mem_req, mem_wr_ena, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, res_src, fault_cause;
  logic [2:0]       imm_src;
  alu_control_t     alu_control;
  logic             fault;
  logic [CNT_W-1:0] instret, cycles;

  rv32i_mc_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_wr_ena(mem_wr_ena), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .res_src(res_src),
    .imm_src(imm_src), .alu_control(alu_control), .fault(fault),
    .fault_cause(fault_cause), .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef enum {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_UPPER, P_JALR, P_JAL, P_ALUWB, P_BRANCH
  } phase_t;

  int               checks = 0;
  int               fails  = 0;
  logic [CNT_W-1:0] exp_cycles, exp_instret;
  phase_t           plan[$];
  logic [6:0]       legal_ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  logic [2:0]       br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  // Compare one observed value with the model and record the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {10'b0, fault, fault_cause, mem_req, mem_wr_ena, adr_src, ir_write,
            pc_write, reg_write, alu_src_a, alu_src_b, res_src, imm_src, alu_control};
  endfunction

  function automatic logic [2:0] imm_fmt(input logic [6:0] o);
    case (o)
      OP_STORE:         return 3'd1;
      OP_BRANCH:        return 3'd2;
      OP_JAL:           return 3'd3;
      OP_LUI, OP_AUIPC: return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  // RV32I arithmetic mnemonic for a funct3/funct7 pair; immediates have no SUB.
  function automatic alu_control_t arith_op(input logic [2:0] f3, input logic f7b5, input bit imm_form);
    case (f3)
      3'd0:    return (f7b5 && !imm_form) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Expected control vector for one cycle of a given phase.
  function automatic logic [31:0] expect_vec(input phase_t ph, input logic [6:0] o,
      input logic [2:0] f3, input logic [6:0] f7, input logic z, input logic l,
      input logic rdy, input logic en);
    logic req, wr, adr, irw, pcw, rw;
    logic [1:0] a, b, rs;
    alu_control_t alu;
    {req, wr, adr, irw, pcw, rw} = '0;
    a = 2'b00; b = 2'b00; rs = 2'b00; alu = ALU_ADD;
    case (ph)
      P_FETCH:    begin req = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; end
      P_MEMREAD:  begin req = 1; adr = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin req = 1; wr = 1; adr = 1; end
      P_EXECR:    begin a = 2'b10; alu = arith_op(f3, f7[5], 1'b0); end
      P_EXECI:    begin a = 2'b10; b = 2'b01; alu = arith_op(f3, f7[5], 1'b1); end
      P_UPPER:    begin a = (o == OP_LUI) ? 2'b11 : 2'b01; b = 2'b01; end
      P_JALR:     begin a = 2'b10; b = 2'b01; end
      P_JAL:      begin pcw = 1; a = 2'b01; b = 2'b10; end
      P_ALUWB:    rw = 1;
      P_BRANCH: begin
        a = 2'b10;
        case (f3)
          3'd0:    begin alu = ALU_SUB;  pcw = z;  end
          3'd1:    begin alu = ALU_SUB;  pcw = !z; end
          3'd4:    begin alu = ALU_SLT;  pcw = l;  end
          3'd5:    begin alu = ALU_SLT;  pcw = !l; end
          3'd6:    begin alu = ALU_SLTU; pcw = l;  end
          default: begin alu = ALU_SLTU; pcw = !l; end
        endcase
      end
      default: ;
    endcase
    if (!en) {req, wr, irw, pcw, rw} = '0;
    return {10'b0, 1'b0, 2'b00, req, wr, adr, irw, pcw, rw, a, b, rs, imm_fmt(o), alu};
  endfunction

  function automatic logic [31:0] fault_vec(input logic [1:0] cause, input logic [6:0] o);
    return {10'b0, 1'b1, cause, 6'b0, 6'b0, imm_fmt(o), ALU_ADD};
  endfunction

  // Phase list of one instruction, from its opcode class.
  task automatic fill_plan(input logic [6:0] o);
    plan.delete();
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (o)
      OP_LOAD:          begin plan.push_back(P_MEMADR); plan.push_back(P_MEMREAD); plan.push_back(P_MEMWB); end
      OP_STORE:         begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWRITE); end
      OP_R:             begin plan.push_back(P_EXECR); plan.push_back(P_ALUWB); end
      OP_I:             begin plan.push_back(P_EXECI); plan.push_back(P_ALUWB); end
      OP_LUI, OP_AUIPC: begin plan.push_back(P_UPPER); plan.push_back(P_ALUWB); end
      OP_JAL:           begin plan.push_back(P_JAL); plan.push_back(P_ALUWB); end
      OP_JALR:          begin plan.push_back(P_JALR); plan.push_back(P_JAL); plan.push_back(P_ALUWB); end
      default:          plan.push_back(P_BRANCH);
    endcase
  endtask

  // Run one instruction start to finish, checking every cycle. Starts and
  // ends just after a rising edge. ncycles counts active (ena = 1) cycles.
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
      input bit rnd, input int fetch_wait, input int mem_wait,
      input int stall_at, input int stall_len, output int ncycles);
    int waits, stalls, limit;
    bit done, is_mem;
    phase_t ph;
    op = o; funct3 = f3; funct7 = f7;
    fill_plan(o);
    ncycles = 0;
    for (int i = 0; i < plan.size(); i++) begin
      ph = plan[i]; waits = 0; stalls = 0; done = 0;
      is_mem = (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE);
      limit  = (ph == P_FETCH) ? fetch_wait : mem_wait;
      for (int guard = 0; guard < 64 && !done; guard++) begin
        if (rnd) begin
          ena = ($urandom_range(0, 5) != 0);
          zero = 1'($urandom_range(0, 1)); alu_lsb = 1'($urandom_range(0, 1));
          if (is_mem) mem_ready = (waits >= TIMEOUT - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
          else        mem_ready = 1'($urandom_range(0, 1));
        end else begin
          ena = !(i == stall_at && stalls < stall_len);
          zero = 1'b0; alu_lsb = 1'b1;
          mem_ready = is_mem ? (waits >= limit) : 1'b1;
        end
        @(negedge clk);
        checkOutput($sformatf("ctrl_%s_op%b_f3%0d", ph.name(), o, f3), dut_vec(),
                    expect_vec(ph, o, f3, f7, zero, alu_lsb, mem_ready, ena));
        @(posedge clk); #1;
        if (ena) begin
          exp_cycles++;
          ncycles++;
          if (!is_mem || mem_ready) done = 1;
          else waits++;
        end else begin
          stalls++;
        end
      end
      checkOutput($sformatf("phase_done_%s", ph.name()), {31'b0, done}, 32'd1);
    end
    exp_instret++;
    ena = 1'b1;
    checkOutput("cycles", cycles, PERF ? exp_cycles : 32'd0);
    checkOutput("instret", instret, PERF ? exp_instret : 32'd0);
  endtask

  // Assert reset, check the reset outputs, release just after a rising edge.
  task automatic do_reset();
    ena = 1'b1; mem_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", {25'b0, mem_req, mem_wr_ena, ir_write, pc_write, reg_write, fault, fault_cause[1]},
                32'd0);
    checkOutput("reset_cause", {30'b0, fault_cause}, 32'd0);
    checkOutput("reset_cycles", cycles, 32'd0);
    checkOutput("reset_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cycles = '0; exp_instret = '0;
  endtask

  task automatic step_check(input string tag, input logic [31:0] expv);
    @(negedge clk);
    checkOutput(tag, dut_vec(), expv);
    @(posedge clk); #1;
  endtask

  initial begin
    int nc;
    logic [6:0] ro, rf7;
    logic [2:0] rf3;
    rst = 1'b0; ena = 1'b1; zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b0;
    op = OP_R; funct3 = 3'd0; funct7 = 7'd0;
    exp_cycles = '0; exp_instret = '0;

    do_reset();

    // Directed instructions with ready tied high unless noted.
    applyStimulus(OP_R, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);      checkOutput("add_cycles", nc, 4);
    applyStimulus(OP_R, 3'd0, 7'h20, 0, 0, 0, -1, 0, nc);      checkOutput("sub_cycles", nc, 4);
    applyStimulus(OP_LOAD, 3'd2, 7'h00, 0, 0, 3, -1, 0, nc);   checkOutput("lw_delay_cycles", nc, 8);
    applyStimulus(OP_STORE, 3'd2, 7'h00, 0, 0, 0, -1, 0, nc);  checkOutput("sw_cycles", nc, 4);
    applyStimulus(OP_BRANCH, 3'd1, 7'h00, 0, 0, 0, -1, 0, nc); checkOutput("bne_cycles", nc, 3);
    applyStimulus(OP_BRANCH, 3'd5, 7'h00, 0, 0, 0, -1, 0, nc); checkOutput("bge_cycles", nc, 3);
    applyStimulus(OP_BRANCH, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);
    applyStimulus(OP_JALR, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);   checkOutput("jalr_cycles", nc, 5);
    applyStimulus(OP_JAL, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);    checkOutput("jal_cycles", nc, 4);
    applyStimulus(OP_LUI, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);
    applyStimulus(OP_AUIPC, 3'd0, 7'h00, 0, 0, 0, -1, 0, nc);
    applyStimulus(OP_I, 3'd5, 7'h20, 0, 0, 0, -1, 0, nc);
    applyStimulus(OP_I, 3'd0, 7'h20, 0, 0, 0, -1, 0, nc);
    // Ready arrives in the last allowed fetch cycle: completes, no fault.
    applyStimulus(OP_R, 3'd7, 7'h00, 0, TIMEOUT - 1, 0, -1, 0, nc);
    checkOutput("boundary_cycles", nc, 3 + TIMEOUT);
    // Five-cycle stall in the middle of EXECR.
    applyStimulus(OP_R, 3'd0, 7'h00, 0, 0, 0, 2, 5, nc);       checkOutput("stall_active_cycles", nc, 4);

    // Random instruction stream with random stalls, waits and compare inputs.
    for (int n = 0; n < 150; n++) begin
      ro  = legal_ops[$urandom_range(0, 8)];
      rf3 = (ro == OP_BRANCH) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      rf7 = 7'($urandom_range(0, 127));
      applyStimulus(ro, rf3, rf7, 1, 0, 0, -1, 0, nc);
    end

    // Fetch never completes: fault after TIMEOUT waiting cycles.
    do_reset();
    op = OP_R; mem_ready = 1'b0;
    for (int c = 0; c < TIMEOUT; c++)
      step_check("timeout_wait", expect_vec(P_FETCH, OP_R, 3'd0, 7'd0, zero, alu_lsb, 1'b0, 1'b1));
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) step_check("timeout_fault", fault_vec(2'b10, OP_R));
    checkOutput("timeout_cycles", cycles, PERF ? 32'd4 : 32'd0);
    checkOutput("timeout_instret", instret, 32'd0);

    // Illegal opcode faults from DECODE.
    do_reset();
    op = 7'b0000000; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b1;
    step_check("illegal_fetch", expect_vec(P_FETCH, op, 3'd0, 7'd0, zero, alu_lsb, 1'b1, 1'b1));
    step_check("illegal_decode", expect_vec(P_DECODE, op, 3'd0, 7'd0, zero, alu_lsb, 1'b1, 1'b1));
    for (int c = 0; c < 3; c++) step_check("illegal_fault", fault_vec(2'b01, op));
    checkOutput("illegal_cycles", cycles, PERF ? 32'd2 : 32'd0);

    // Reset in the middle of a load restarts cleanly at FETCH.
    do_reset();
    op = OP_LOAD; funct3 = 3'd2; mem_ready = 1'b1;
    step_check("mid_fetch", expect_vec(P_FETCH, op, 3'd2, 7'd0, zero, alu_lsb, 1'b1, 1'b1));
    step_check("mid_decode", expect_vec(P_DECODE, op, 3'd2, 7'd0, zero, alu_lsb, 1'b1, 1'b1));
    step_check("mid_memadr", expect_vec(P_MEMADR, op, 3'd2, 7'd0, zero, alu_lsb, 1'b1, 1'b1));
    mem_ready = 1'b0;
    step_check("mid_memread", expect_vec(P_MEMREAD, op, 3'd2, 7'd0, zero, alu_lsb, 1'b0, 1'b1));
    do_reset();
    applyStimulus(OP_R, 3'd4, 7'h00, 0, 0, 0, -1, 0, nc);      checkOutput("after_reset_cycles", nc, 4);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
